sram_responder: RTL



---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_read_pipe.sv | 37 +++
 rtl/sram_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, read-pipe entry type and lane-mask helper for the SRAM responder
package sram_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;

  typedef struct packed {
    logic                   valid;
    logic [SRAM_DATA_W-1:0] data;
    logic                   ub_n;
    logic                   lb_n;
  } pipe_entry_t;

  // Bit mask of the byte lanes enabled by the active-low UB_N/LB_N pair.
  function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic ub_n, input logic lb_n);
    return {{(SRAM_DATA_W/2){~ub_n}}, {(SRAM_DATA_W/2){~lb_n}}};
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// rtl/sram_read_pipe.sv - READ_LAT-deep shift register of read-pipe entries, async active-low clear
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pipe_entry_t in_entry,
  output pipe_entry_t out_entry
);

  pipe_entry_t stage_q [READ_LAT];
  pipe_entry_t stage_d [READ_LAT];

  always_comb begin
    stage_d[0] = in_entry;
    for (int i = 1; i < READ_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_entry = stage_q[READ_LAT-1];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - device-side model of the 256Kx16 SRAM bus with byte lanes, pipelined reads
// and a protocol checker; counters/checker are built only with SRAM_RESPONDER_STATS_EN defined.
module sram_responder
  import sram_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int READ_LAT       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  input  logic                   SRAM_UB_N,
  input  logic                   SRAM_LB_N,
  input  logic                   SRAM_WE_N,
  input  logic                   SRAM_CE_N,
  input  logic                   SRAM_OE_N,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count,
  output logic                   proto_err
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;

  logic [SRAM_DATA_W-1:0]    mem_q [MEM_DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] word_addr;
  logic                      unused_addr;
  logic                      wr_cycle;
  logic                      rd_issue;
  logic                      drive_en;
  logic [SRAM_DATA_W-1:0]    wr_mask;
  logic [SRAM_DATA_W-1:0]    wr_data;
  pipe_entry_t               issue_entry;
  pipe_entry_t               last_entry;

  // Upper address bits are ignored: the array aliases modulo its depth.
  assign word_addr   = SRAM_ADDR[MEM_DEPTH_LOG2-1:0];
  assign unused_addr = ^SRAM_ADDR[SRAM_ADDR_W-1:MEM_DEPTH_LOG2];

  assign wr_cycle = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_issue = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign wr_mask  = lane_mask(SRAM_UB_N, SRAM_LB_N);
  assign wr_data  = (mem_q[word_addr] & ~wr_mask) | (SRAM_DQ & wr_mask);

  always_ff @(posedge clk) begin
    if (wr_cycle) begin
      mem_q[word_addr] <= wr_data;
    end
  end

  assign issue_entry.valid = rd_issue;
  assign issue_entry.data  = mem_q[word_addr];
  assign issue_entry.ub_n  = SRAM_UB_N;
  assign issue_entry.lb_n  = SRAM_LB_N;

  sram_read_pipe #(
    .READ_LAT (READ_LAT)
  ) u_read_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .in_entry  (issue_entry),
    .out_entry (last_entry)
  );

  // Bus controls are re-checked at drive time so the master can abort a read by releasing OE/CE.
  assign drive_en = last_entry.valid && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[15:8] = (drive_en && !last_entry.ub_n) ? last_entry.data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive_en && !last_entry.lb_n) ? last_entry.data[7:0]  : 8'hzz;

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        proto_err_q, proto_err_d;

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    if (drive_en) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_cycle) begin
      wr_count_d = wr_count_q + 16'd1;
      if (!SRAM_OE_N || last_entry.valid) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
      proto_err_q <= 1'b0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign proto_err = proto_err_q;
`else
  assign rd_count  = 16'd0;
  assign wr_count  = 16'd0;
  assign proto_err = 1'b0;
`endif

endmodule
